// File: rtl/display_rect_engine.sv
// Single filled-rectangle generator over a background colour, driven by the sync counters.
// Geometry and colours live in pending registers and are copied to the active set once per frame.
module display_rect_engine #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int STEP     = 2,
  parameter int BLINK_FR = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  input  logic          video_on,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [CW-1:0] wr_data,
  output logic [2:0]    rgb_out,
  output logic          frame_tick
);

  localparam int BW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  localparam logic [CW-1:0] X_DEF    = CW'(191);
  localparam logic [CW-1:0] Y_DEF    = CW'(101);
  localparam logic [CW-1:0] W_DEF    = CW'(359);
  localparam logic [CW-1:0] H_DEF    = CW'(269);
  localparam logic [2:0]    FG_DEF   = 3'b111;
  localparam logic [2:0]    BG_DEF   = 3'b000;
  localparam logic [2:0]    CTRL_DEF = 3'b001;
  localparam logic [CW:0]   H_LIM    = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   V_LIM    = (CW+1)'(V_ACTIVE);
  localparam logic [CW-1:0] STEP_V   = CW'(STEP);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FR - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_STATIC = 2'd1,
    ST_BOUNCE = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] p_x, p_y, p_w, p_h;
  logic [2:0]    p_fg, p_bg, p_ctrl;
  logic [CW-1:0] a_x, a_y, a_w, a_h;
  logic [2:0]    a_fg, a_bg;
  logic          dir_x, dir_y;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  logic          commit;
  logic          hit;
  logic [CW:0]   x_end, y_end;
  logic [CW:0]   x_step, y_step;

  // One bounce move along an axis; result is {new_dir, new_pos}.
  function automatic logic [CW:0] axis_step(input logic [CW-1:0] pos,
                                            input logic [CW-1:0] len,
                                            input logic          dir,
                                            input logic [CW:0]   limit);
    logic [CW:0] far;
    far = {1'b0, pos} + {1'b0, len} + {1'b0, STEP_V};
    if (!dir) begin
      if (far > limit) axis_step = {1'b1, pos - STEP_V};
      else             axis_step = {1'b0, pos + STEP_V};
    end else begin
      if (pos < STEP_V) axis_step = {1'b0, pos + STEP_V};
      else              axis_step = {1'b1, pos - STEP_V};
    end
  endfunction

  always_comb begin
    commit = (hcount == '0) && (vcount == CW'(V_ACTIVE));
    if (!p_ctrl[0])     next_state = ST_OFF;
    else if (p_ctrl[1]) next_state = ST_BOUNCE;
    else                next_state = ST_STATIC;
    x_step = axis_step(p_x, p_w, dir_x, H_LIM);
    y_step = axis_step(p_y, p_h, dir_y, V_LIM);
    // Widened sums so a box touching the top of the counter range cannot wrap.
    x_end = {1'b0, a_x} + {1'b0, a_w};
    y_end = {1'b0, a_y} + {1'b0, a_h};
    hit   = (hcount >= a_x) && ({1'b0, hcount} < x_end) &&
            (vcount >= a_y) && ({1'b0, vcount} < y_end);
  end

  // Host writes are applied last so a write on the commit cycle beats the bounce write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_x         <= X_DEF;
      p_y         <= Y_DEF;
      p_w         <= W_DEF;
      p_h         <= H_DEF;
      p_fg        <= FG_DEF;
      p_bg        <= BG_DEF;
      p_ctrl      <= CTRL_DEF;
      a_x         <= X_DEF;
      a_y         <= Y_DEF;
      a_w         <= W_DEF;
      a_h         <= H_DEF;
      a_fg        <= FG_DEF;
      a_bg        <= BG_DEF;
      dir_x       <= 1'b0;
      dir_y       <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      state       <= ST_STATIC;
      rgb_out     <= 3'b000;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= commit;
      if (!video_on)
        rgb_out <= 3'b000;
      else if (hit && (state != ST_OFF) && !blink_phase)
        rgb_out <= a_fg;
      else
        rgb_out <= a_bg;

      if (commit) begin
        state <= next_state;
        a_x   <= p_x;
        a_y   <= p_y;
        a_w   <= p_w;
        a_h   <= p_h;
        a_fg  <= p_fg;
        a_bg  <= p_bg;
        if (next_state == ST_BOUNCE) begin
          a_x   <= x_step[CW-1:0];
          a_y   <= y_step[CW-1:0];
          p_x   <= x_step[CW-1:0];
          p_y   <= y_step[CW-1:0];
          dir_x <= x_step[CW];
          dir_y <= y_step[CW];
        end
        if (p_ctrl[2]) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end else begin
          blink_cnt   <= '0;
          blink_phase <= 1'b0;
        end
      end

      if (wr_en) begin
        case (wr_addr)
          3'd0:    p_x    <= wr_data;
          3'd1:    p_y    <= wr_data;
          3'd2:    p_w    <= wr_data;
          3'd3:    p_h    <= wr_data;
          3'd4:    p_fg   <= wr_data[2:0];
          3'd5:    p_bg   <= wr_data[2:0];
          3'd6:    p_ctrl <= wr_data[2:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_rect_engine.sv
// Directed bench for display_rect_engine: drives hcount/vcount directly and checks
// pixels against hand-computed rectangle positions, colours and frame-tick timing.
module tb_display_rect_engine;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          video_on;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [CW-1:0] wr_data;
  logic [2:0]    rgb_out;
  logic          frame_tick;

  int checks = 0;
  int errors = 0;

  display_rect_engine #(
    .CW(CW), .H_ACTIVE(640), .V_ACTIVE(480), .STEP(2), .BLINK_FR(3)
  ) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rgb_out(rgb_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_val(input string tag, input logic [3:0] obs, input int exp);
    logic [3:0] e;
    e = exp[3:0];
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  task automatic apply_stimulus(input int h, input int v, input logic von);
    @(negedge clk);
    hcount   = h[CW-1:0];
    vcount   = v[CW-1:0];
    video_on = von;
  endtask

  task automatic check_output(input int h, input int v, input logic von,
                              input int exp, input string tag);
    apply_stimulus(h, v, von);
    @(posedge clk);
    #1;
    check_val(tag, {1'b0, rgb_out}, exp);
  endtask

  task automatic write_reg(input int addr, input int data);
    @(negedge clk);
    hcount   = 10'd5;
    vcount   = 10'd5;
    video_on = 1'b0;
    wr_en    = 1'b1;
    wr_addr  = addr[2:0];
    wr_data  = data[CW-1:0];
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic commit_frame(input logic with_wr, input int addr, input int data);
    @(negedge clk);
    hcount   = 10'd0;
    vcount   = 10'd480;
    video_on = 1'b0;
    wr_en    = with_wr;
    wr_addr  = addr[2:0];
    wr_data  = data[CW-1:0];
    @(posedge clk);
    #1;
    check_val("tick_set", {3'b000, frame_tick}, 1);
    @(negedge clk);
    wr_en    = 1'b0;
    hcount   = 10'd5;
    vcount   = 10'd5;
    @(posedge clk);
    #1;
    check_val("tick_clear", {3'b000, frame_tick}, 0);
  endtask

  initial begin
    hcount   = 10'd5;
    vcount   = 10'd5;
    video_on = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = '0;

    // Reset state, including a would-be hit pixel while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rgb", {1'b0, rgb_out}, 0);
    check_val("rst_tick", {3'b000, frame_tick}, 0);
    check_output(300, 200, 1'b1, 0, "rst_hold_rgb");
    @(negedge clk);
    reset = 1'b0;

    // Default box: h 191..549, v 101..369, FG 7 over BG 0.
    check_output(191, 101, 1'b1, 7, "def_tl");
    check_output(190, 101, 1'b1, 0, "def_left");
    check_output(549, 101, 1'b1, 7, "def_tr");
    check_output(550, 101, 1'b1, 0, "def_right");
    check_output(191, 100, 1'b1, 0, "def_above");
    check_output(191, 369, 1'b1, 7, "def_bl");
    check_output(191, 370, 1'b1, 0, "def_below");
    check_output(549, 369, 1'b1, 7, "def_br");
    check_output(300, 200, 1'b0, 0, "def_blank");
    check_output(300, 200, 1'b1, 7, "def_mid");
    check_output(0, 0, 1'b1, 0, "def_lag");
    check_output(639, 479, 1'b1, 0, "def_corner");

    // Mid-frame writes stay pending until the next commit.
    write_reg(0, 20);
    write_reg(2, 10);
    check_output(191, 200, 1'b1, 7, "wr_pending_old");
    check_output(20, 200, 1'b1, 0, "wr_pending_new");
    commit_frame(1'b0, 0, 0);
    check_output(20, 200, 1'b1, 7, "wr_left");
    check_output(29, 200, 1'b1, 7, "wr_right");
    check_output(30, 200, 1'b1, 0, "wr_past");
    check_output(19, 200, 1'b1, 0, "wr_before");
    check_output(191, 200, 1'b1, 0, "wr_old_gone");

    // Colour change plus an X write landing on the commit cycle itself.
    write_reg(4, 4);
    write_reg(5, 2);
    commit_frame(1'b1, 0, 100);
    check_output(20, 200, 1'b1, 4, "cw_still_old");
    check_output(100, 200, 1'b1, 2, "cw_not_yet");
    check_output(300, 200, 1'b0, 0, "cw_blank");
    commit_frame(1'b0, 0, 0);
    check_output(100, 200, 1'b1, 4, "cw_applied");
    check_output(20, 200, 1'b1, 2, "cw_old_gone");

    // Bounce on X near the right edge: 627 -> 629 -> 627 (turn) -> 625.
    write_reg(0, 627);
    write_reg(2, 10);
    write_reg(6, 3);
    commit_frame(1'b0, 0, 0);
    check_output(628, 200, 1'b1, 2, "bx1_before");
    check_output(629, 200, 1'b1, 4, "bx1_left");
    check_output(638, 200, 1'b1, 4, "bx1_right");
    check_output(639, 200, 1'b1, 2, "bx1_past");
    commit_frame(1'b0, 0, 0);
    check_output(626, 200, 1'b1, 2, "bx2_before");
    check_output(627, 200, 1'b1, 4, "bx2_left");
    check_output(636, 200, 1'b1, 4, "bx2_right");
    check_output(637, 200, 1'b1, 2, "bx2_past");
    commit_frame(1'b0, 0, 0);
    check_output(624, 200, 1'b1, 2, "bx3_before");
    check_output(625, 200, 1'b1, 4, "bx3_left");

    // Left-edge turn with dir_x=1 from X=1, and bottom-edge turn on Y.
    write_reg(0, 1);
    write_reg(1, 471);
    write_reg(3, 8);
    commit_frame(1'b0, 0, 0);
    check_output(3, 469, 1'b1, 4, "edge_x3_y469");
    check_output(2, 469, 1'b1, 2, "edge_x2");
    check_output(3, 468, 1'b1, 2, "edge_y468");
    check_output(3, 476, 1'b1, 4, "edge_y476");
    check_output(3, 477, 1'b1, 2, "edge_y477");
    commit_frame(1'b0, 0, 0);
    check_output(5, 467, 1'b1, 4, "edge2_hit");
    check_output(4, 467, 1'b1, 2, "edge2_x4");
    check_output(5, 466, 1'b1, 2, "edge2_y466");
    write_reg(1, 1);
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 4, "top_hit");
    check_output(7, 2, 1'b1, 2, "top_above");

    // Blink with BLINK_FR=3 in static mode: position frozen at (7,3).
    write_reg(6, 5);
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 4, "blink_c1");
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 4, "blink_c2");
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 2, "blink_c3");
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 2, "blink_c4");
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 2, "blink_c5");
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 4, "blink_c6");

    // Disabled: whole screen background.
    write_reg(6, 0);
    commit_frame(1'b0, 0, 0);
    check_output(7, 3, 1'b1, 2, "off_box");
    check_output(300, 200, 1'b1, 2, "off_mid");

    // Resume bounce from (7,3) then assert reset mid-line.
    write_reg(6, 3);
    commit_frame(1'b0, 0, 0);
    check_output(9, 5, 1'b1, 4, "rb_hit");
    check_output(8, 5, 1'b1, 2, "rb_left");
    apply_stimulus(300, 200, 1'b1);
    @(posedge clk);
    #1;
    check_val("pre_reset_rgb", {1'b0, rgb_out}, 2);
    #1;
    reset = 1'b1;
    #1;
    check_val("async_rst_rgb", {1'b0, rgb_out}, 0);
    check_val("async_rst_tick", {3'b000, frame_tick}, 0);
    @(negedge clk);
    reset = 1'b0;
    check_output(191, 101, 1'b1, 7, "post_rst_tl");
    check_output(190, 101, 1'b1, 0, "post_rst_left");
    check_output(549, 369, 1'b1, 7, "post_rst_br");
    check_output(550, 369, 1'b1, 0, "post_rst_right");
    check_output(9, 5, 1'b1, 0, "post_rst_oldbox");
    commit_frame(1'b0, 0, 0);
    check_output(191, 101, 1'b1, 7, "post_rst_static");

    // Address 7 is ignored; W=0 suppresses every FG pixel.
    write_reg(7, 0);
    commit_frame(1'b0, 0, 0);
    check_output(191, 101, 1'b1, 7, "addr7_ignored");
    write_reg(2, 0);
    commit_frame(1'b0, 0, 0);
    check_output(191, 101, 1'b1, 0, "w0_tl");
    check_output(300, 200, 1'b1, 0, "w0_mid");
    check_output(191, 369, 1'b1, 0, "w0_bl");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
